apb_cmd_master: RTL and testbench

//  APB requester stage feeding the two 8-bit APB slaves (slave1/slave2) on the shared bus.
//  - Accepts one read/write command at a time on a valid/ready command port.
//  - Runs the APB SETUP -> ACCESS sequence and decodes the target slave (PSEL1/PSEL2).
//  - Muxes PRDATA1/PRDATA2 and returns a one-cycle response.
//  - Aborts with an error if PREADY does not arrive within a bounded wait.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_sel_decode.sv | 11 +
 rtl/apb_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB widths and the requester FSM state type.
package apb_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_sel_decode.sv
// Slave select decode: one address bit -> one-hot {PSEL2, PSEL1} and PRDATA mux select.
module apb_sel_decode (
    input  logic       sel_bit,
    output logic [1:0] psel_onehot,
    output logic       rdata_sel
);

    assign psel_onehot = sel_bit ? 2'b10 : 2'b01;
    assign rdata_sel   = sel_bit;

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: takes one valid/ready command, runs SETUP -> ACCESS on slave1/slave2,
// returns a one-cycle response, and aborts with rsp_err if PREADY never arrives.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned SEL_BIT        = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [APB_AW:0]   cmd_addr,
    input  logic [APB_DW-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [APB_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA1,
    input  logic [APB_DW-1:0] PRDATA2,
    input  logic              PREADY
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d;
    logic              rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        dec_psel;
    logic              dec_rd_sel;

    apb_sel_decode u_sel_decode (
        .sel_bit     (cmd_addr[SEL_BIT]),
        .psel_onehot (dec_psel),
        .rdata_sel   (dec_rd_sel)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rd_sel_d    = rd_sel_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d            = ST_SETUP;
                    cmd_ready_d        = 1'b0;
                    pwrite_d           = cmd_write;
                    paddr_d            = cmd_addr[APB_AW-1:0];
                    pwdata_d           = cmd_wdata;
                    {psel2_d, psel1_d} = dec_psel;
                    rd_sel_d           = dec_rd_sel;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                // PREADY is checked before the limit so a last-cycle ready still succeeds.
                if (PREADY || (cnt_q == CNT_LAST)) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (PREADY) begin
                        if (!pwrite_q) rsp_rdata_d = rd_sel_q ? PRDATA2 : PRDATA1;
                    end else begin
                        rsp_err_d = 1'b1;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel1_d     = 1'b0;
                psel2_d     = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rd_sel_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rd_sel_q    <= rd_sel_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL1     = psel1_q;
    assign PSEL2     = psel2_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with two behavioural APB slaves and programmable PREADY.
module tb_apb_cmd_master;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [8:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       PSEL1, PSEL2, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    int         acc_cnt = 0;
    int         wait_states = 0;
    bit         never_ready = 0;
    bit         force_ready = 0;

    apb_cmd_master #(.TIMEOUT_CYCLES(16), .SEL_BIT(8)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    assign PRDATA1 = mem1[PADDR];
    assign PRDATA2 = mem2[PADDR];
    assign PREADY  = force_ready || (!never_ready && PENABLE && (acc_cnt >= wait_states));

    always @(posedge PCLK) begin
        if (PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                    acc_cnt <= 0;
        if (PENABLE && PREADY && PWRITE) begin
            if (PSEL1) mem1[PADDR] <= PWDATA;
            if (PSEL2) mem2[PADDR] <= PWDATA;
        end
    end

    task automatic do_cmd(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic err,
                          output logic s1, output logic s2);
        int w;
        w = 0; s1 = 0; s2 = 0; lat = 0;
        @(negedge PCLK);
        while (!cmd_ready && w < 20) begin @(negedge PCLK); w++; end
        nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready); end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(negedge PCLK);
        cmd_valid = 0; lat = 1;
        while (!rsp_valid && lat < 40) begin
            s1 |= PSEL1; s2 |= PSEL2;
            @(negedge PCLK); lat++;
        end
        rd = rsp_rdata; err = rsp_err;
    endtask

    task automatic test_reset();
        PRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge PCLK);
        PRESET = 0;
        nvec++;
        if ({cmd_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata} !== {1'b1, 6'b0, 24'h0}) begin
            nerr++;
            $display("FAIL reset_state: got rdy=%b rv=%b err=%b s1=%b s2=%b en=%b wr=%b a=%h wd=%h rd=%h want rdy=1 rest 0",
                     cmd_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata);
        end
    endtask

    task automatic test_write_zero_wait();
        @(negedge PCLK);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 9'h105; cmd_wdata = 8'hA5;
        @(negedge PCLK);   // cycle N+1: SETUP
        cmd_valid = 0;
        nvec++; if ({PSEL1, PSEL2, PENABLE, PWRITE, cmd_ready} !== 5'b01010) begin nerr++; $display("FAIL wr_setup_ctrl: got s1s2enwrrdy=%b want 01010", {PSEL1, PSEL2, PENABLE, PWRITE, cmd_ready}); end
        nvec++; if ({PADDR, PWDATA} !== 16'h05A5) begin nerr++; $display("FAIL wr_setup_bus: got %h want 05a5", {PADDR, PWDATA}); end
        @(negedge PCLK);   // cycle N+2: ACCESS
        nvec++; if ({PSEL2, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b110, 16'h05A5}) begin nerr++; $display("FAIL wr_access: got %b %h want 110 05a5", {PSEL2, PENABLE, rsp_valid}, {PADDR, PWDATA}); end
        @(negedge PCLK);   // cycle N+3: response
        nvec++; if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready} !== {2'b10, 8'h00, 1'b1}) begin nerr++; $display("FAIL wr_rsp: got v=%b e=%b d=%h rdy=%b want v=1 e=0 d=00 rdy=1", rsp_valid, rsp_err, rsp_rdata, cmd_ready); end
        nvec++; if ({PSEL1, PSEL2, PENABLE, PADDR, PWDATA} !== {3'b000, 16'h05A5}) begin nerr++; $display("FAIL wr_idle_hold: got %b %h want 000 05a5", {PSEL1, PSEL2, PENABLE}, {PADDR, PWDATA}); end
        @(negedge PCLK);
        nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
        nvec++; if (mem2[8'h05] !== 8'hA5) begin nerr++; $display("FAIL wr_slave2_mem: got %h want a5", mem2[8'h05]); end
    endtask

    task automatic test_read_back();
        int lat; logic [7:0] rd; logic err, s1, s2;
        do_cmd(1'b0, 9'h105, 8'h00, lat, rd, err, s1, s2);
        nvec++; if ({lat, rd, err, s1, s2} !== {32'd3, 8'hA5, 3'b001}) begin nerr++; $display("FAIL read_back: got lat=%0d d=%h e=%b s1=%b s2=%b want 3 a5 0 0 1", lat, rd, err, s1, s2); end
    endtask

    task automatic test_wait_states();
        int lat; logic [7:0] rd; logic err, s1, s2;
        wait_states = 3;
        do_cmd(1'b0, 9'h010, 8'h00, lat, rd, err, s1, s2);
        wait_states = 0;
        nvec++; if ({lat, rd, err, s1, s2} !== {32'd6, 8'h3C, 3'b010}) begin nerr++; $display("FAIL wait3_read: got lat=%0d d=%h e=%b s1=%b s2=%b want 6 3c 0 1 0", lat, rd, err, s1, s2); end
    endtask

    task automatic test_timeout();
        int lat; logic [7:0] rd; logic err, s1, s2;
        never_ready = 1;
        do_cmd(1'b0, 9'h123, 8'h00, lat, rd, err, s1, s2);
        nvec++; if ({lat, rd, err} !== {32'd18, 8'h00, 1'b1}) begin nerr++; $display("FAIL timeout_rsp: got lat=%0d d=%h e=%b want 18 00 1", lat, rd, err); end
        nvec++; if ({PSEL1, PSEL2, PENABLE, cmd_ready} !== 4'b0001) begin nerr++; $display("FAIL timeout_bus_idle: got %b want 0001", {PSEL1, PSEL2, PENABLE, cmd_ready}); end
        @(negedge PCLK);
        never_ready = 0;
        nvec++; if ({rsp_valid, rsp_err} !== 2'b00) begin nerr++; $display("FAIL timeout_pulse: got %b want 00", {rsp_valid, rsp_err}); end
    endtask

    task automatic test_ready_at_limit();
        int lat; logic [7:0] rd; logic err, s1, s2;
        wait_states = 15;
        do_cmd(1'b0, 9'h010, 8'h00, lat, rd, err, s1, s2);
        wait_states = 0;
        nvec++; if ({lat, rd, err} !== {32'd18, 8'h3C, 1'b0}) begin nerr++; $display("FAIL ready_at_limit: got lat=%0d d=%h e=%b want 18 3c 0", lat, rd, err); end
    endtask

    task automatic test_ready_outside_access();
        int lat; logic [7:0] rd; logic err, s1, s2;
        force_ready = 1;
        repeat (3) @(negedge PCLK);
        nvec++; if ({rsp_valid, PSEL1, PSEL2, PENABLE, cmd_ready} !== 5'b00001) begin nerr++; $display("FAIL ready_in_idle: got %b want 00001", {rsp_valid, PSEL1, PSEL2, PENABLE, cmd_ready}); end
        do_cmd(1'b0, 9'h010, 8'h00, lat, rd, err, s1, s2);
        force_ready = 0;
        nvec++; if ({lat, rd, err} !== {32'd3, 8'h3C, 1'b0}) begin nerr++; $display("FAIL ready_in_setup: got lat=%0d d=%h e=%b want 3 3c 0", lat, rd, err); end
    endtask

    task automatic test_reset_mid_access();
        never_ready = 1;
        @(negedge PCLK);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 9'h0FF; cmd_wdata = 8'h99;
        @(negedge PCLK);
        cmd_valid = 0;
        @(negedge PCLK);
        nvec++; if ({PSEL1, PENABLE} !== 2'b11) begin nerr++; $display("FAIL rst_pre_access: got %b want 11", {PSEL1, PENABLE}); end
        PRESET = 1;
        @(negedge PCLK);
        nvec++; if ({PSEL1, PSEL2, PENABLE, rsp_valid, cmd_ready} !== 5'b00001) begin nerr++; $display("FAIL rst_mid_access: got %b want 00001", {PSEL1, PSEL2, PENABLE, rsp_valid, cmd_ready}); end
        PRESET = 0; never_ready = 0;
        @(negedge PCLK);
        nvec++; if ({rsp_valid, cmd_ready, PSEL1} !== 3'b010) begin nerr++; $display("FAIL rst_after: got %b want 010", {rsp_valid, cmd_ready, PSEL1}); end
    endtask

    task automatic test_back_to_back();
        logic       c_wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] c_ad [4] = '{9'h030, 9'h130, 9'h031, 9'h131};
        logic [7:0] c_wd [4] = '{8'h00, 8'h00, 8'h5A, 8'h00};
        logic [7:0] e_rd [4] = '{8'h11, 8'h22, 8'h00, 8'h44};
        int idx, rsp_i, cyc, last_acc;
        idx = 0; rsp_i = 0; cyc = 0; last_acc = -10;
        while (rsp_i < 4 && cyc < 60) begin
            @(negedge PCLK); cyc++;
            if (rsp_valid) begin
                nvec++; if ({rsp_rdata, rsp_err} !== {e_rd[rsp_i], 1'b0} || rsp_i >= idx) begin nerr++; $display("FAIL b2b_rsp%0d: got d=%h e=%b accepted=%0d want d=%h e=0", rsp_i, rsp_rdata, rsp_err, idx, e_rd[rsp_i]); end
                rsp_i++;
            end
            if (idx < 4) begin
                cmd_valid = 1; cmd_write = c_wr[idx]; cmd_addr = c_ad[idx]; cmd_wdata = c_wd[idx];
                if (cmd_ready) begin
                    nvec++; if (cyc - last_acc < 3) begin nerr++; $display("FAIL b2b_spacing%0d: got %0d want >=3", idx, cyc - last_acc); end
                    last_acc = cyc; idx++;
                end
            end else begin
                cmd_valid = 0;
            end
        end
        cmd_valid = 0;
        nvec++; if (rsp_i !== 4) begin nerr++; $display("FAIL b2b_count: got %0d want 4", rsp_i); end
        nvec++; if (mem1[8'h31] !== 8'h5A) begin nerr++; $display("FAIL b2b_write: got %h want 5a", mem1[8'h31]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem1[i] = 8'h00; mem2[i] = 8'h00; end
        mem1[8'h10] = 8'h3C; mem2[8'h10] = 8'hC3;
        mem2[8'h23] = 8'h77;
        mem1[8'h30] = 8'h11; mem2[8'h30] = 8'h22;
        mem1[8'h31] = 8'hEE; mem2[8'h31] = 8'h44;
        test_reset();
        test_write_zero_wait();
        test_read_back();
        test_wait_states();
        test_timeout();
        test_ready_at_limit();
        test_ready_outside_access();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
